// File: rtl/multi_alarm.sv
`default_nettype none
// ============================================================================
// Module      : multi_alarm
// Description : N-channel alarm controller for the watch. Handles key-driven
//               alarm editing, minute-match ringing, snooze and ring timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_alarm #(
    parameter int N_ALARMS       = 4,
    parameter int DEBOUNCE_TICKS = 500000,
    parameter int LONG_TICKS     = 100000000,
    parameter int RING_SECS      = 60,
    parameter int SNOOZE_MIN     = 5
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [1:0]                  KEY,
    input  logic [1:0]                  mode,
    input  logic [7:0]                  hour,
    input  logic [7:0]                  min,
    input  logic                        sec_tick,
    output logic [7:0]                  disp_hour,
    output logic [7:0]                  disp_min,
    output logic [$clog2(N_ALARMS)-1:0] sel_idx,
    output logic                        sel_field,
    output logic [N_ALARMS-1:0]         armed,
    output logic                        ring,
    output logic [$clog2(N_ALARMS)-1:0] ring_idx,
    output logic                        snoozing
);

    localparam int c_IW = $clog2(N_ALARMS);
    localparam int c_DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int c_HW = $clog2(LONG_TICKS + 1);
    localparam int c_SW = $clog2(RING_SECS + 1);

    localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEBOUNCE_TICKS - 1);
    localparam logic [c_HW-1:0] c_LONG      = c_HW'(LONG_TICKS);
    localparam logic [c_HW-1:0] c_LONG_LAST = c_HW'(LONG_TICKS - 1);
    localparam logic [c_SW-1:0] c_RING_LAST = c_SW'(RING_SECS - 1);
    localparam logic [c_IW-1:0] c_SEL_LAST  = c_IW'(N_ALARMS - 1);
    localparam logic [7:0]      c_SNOOZE    = 8'(SNOOZE_MIN);

    logic [1:0] w_short;
    logic [1:0] w_long;

    // Per key: synchroniser, debounce, and held-time tracker (pressed = high).
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic            r_sync0;
        logic            r_sync1;
        logic            r_db;
        logic [c_DW-1:0] r_db_cnt;
        logic [c_HW-1:0] r_held;

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                r_sync0  <= 1'b0;
                r_sync1  <= 1'b0;
                r_db     <= 1'b0;
                r_db_cnt <= '0;
                r_held   <= '0;
            end else begin
                r_sync0 <= ~KEY[k];
                r_sync1 <= r_sync0;
                if (r_sync1 == r_db) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DEB_LAST) begin
                    r_db     <= r_sync1;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DW'(1);
                end
                if (!r_db) begin
                    r_held <= '0;
                end else if (r_held != c_LONG) begin
                    r_held <= r_held + c_HW'(1);
                end
            end
        end

        // A saturated held count means a LONG already fired, so release is silent.
        assign w_long[k]  = r_db && (r_held == c_LONG_LAST);
        assign w_short[k] = !r_db && (r_held != '0) && (r_held < c_LONG);
    end

    logic [7:0]      r_alm_h [N_ALARMS];
    logic [7:0]      r_alm_m [N_ALARMS];
    logic [N_ALARMS-1:0] r_armed;
    logic [c_IW-1:0] r_sel;
    logic            r_field;
    logic            r_ring;
    logic [c_IW-1:0] r_ring_idx;
    logic            r_snz;
    logic [7:0]      r_snz_h;
    logic [7:0]      r_snz_m;
    logic [7:0]      r_ring_h;
    logic [7:0]      r_ring_m;
    logic [7:0]      r_prev_h;
    logic [7:0]      r_prev_m;
    logic [c_SW-1:0] r_sec_cnt;

    logic            w_ev0;
    logic            w_ev1;
    logic            w_edit;
    logic            w_min_change;
    logic            w_match_any;
    logic [c_IW-1:0] w_match_idx;
    logic            w_snz_match;
    logic            w_trigger;
    logic [7:0]      w_snz_sum;
    logic            w_snz_wrap;
    logic [7:0]      w_snz_h;
    logic [7:0]      w_snz_m;

    assign w_ev0        = w_short[0] | w_long[0];
    assign w_ev1        = w_short[1] | w_long[1];
    assign w_edit       = (mode == 2'd3) && !r_ring;
    assign w_min_change = (hour != r_prev_h) || (min != r_prev_m);
    assign w_snz_match  = r_snz && (r_snz_h == hour) && (r_snz_m == min);
    assign w_trigger    = w_min_change && !r_ring && (w_match_any || w_snz_match);

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_match_any = 1'b0;
        w_match_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (r_armed[i] && (r_alm_h[i] == hour) && (r_alm_m[i] == min)) begin
                w_match_any = 1'b1;
                w_match_idx = c_IW'(i);
            end
        end
    end

    assign w_snz_sum  = r_ring_m + c_SNOOZE;
    assign w_snz_wrap = (w_snz_sum >= 8'd60);
    assign w_snz_m    = w_snz_wrap ? (w_snz_sum - 8'd60) : w_snz_sum;
    assign w_snz_h    = !w_snz_wrap ? r_ring_h :
                        (r_ring_h == 8'd23) ? 8'd0 : (r_ring_h + 8'd1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                r_alm_h[i] <= '0;
                r_alm_m[i] <= '0;
            end
            r_armed    <= '0;
            r_sel      <= '0;
            r_field    <= 1'b0;
            r_ring     <= 1'b0;
            r_ring_idx <= '0;
            r_snz      <= 1'b0;
            r_snz_h    <= '0;
            r_snz_m    <= '0;
            r_ring_h   <= '0;
            r_ring_m   <= '0;
            r_sec_cnt  <= '0;
            r_prev_h   <= hour;
            r_prev_m   <= min;
        end else begin
            r_prev_h <= hour;
            r_prev_m <= min;
            if (r_ring) begin
                if (w_ev0) begin
                    r_ring    <= 1'b0;
                    r_snz     <= 1'b0;
                    r_sec_cnt <= '0;
                end else if (w_ev1) begin
                    r_ring    <= 1'b0;
                    r_snz     <= 1'b1;
                    r_snz_h   <= w_snz_h;
                    r_snz_m   <= w_snz_m;
                    r_sec_cnt <= '0;
                end else if (sec_tick) begin
                    if (r_sec_cnt == c_RING_LAST) begin
                        r_ring    <= 1'b0;
                        r_sec_cnt <= '0;
                    end else begin
                        r_sec_cnt <= r_sec_cnt + c_SW'(1);
                    end
                end
            end else begin
                if (w_trigger) begin
                    r_ring    <= 1'b1;
                    r_sec_cnt <= '0;
                    r_ring_h  <= hour;
                    r_ring_m  <= min;
                    if (w_match_any) begin
                        r_ring_idx <= w_match_idx;
                    end
                    if (w_snz_match) begin
                        r_snz <= 1'b0;
                    end
                end
                if (w_edit) begin
                    if (w_ev0) begin
                        if (w_long[0]) begin
                            r_sel   <= (r_sel == c_SEL_LAST) ? '0 : (r_sel + c_IW'(1));
                            r_field <= 1'b0;
                        end else begin
                            r_armed[r_sel] <= ~r_armed[r_sel];
                        end
                    end else if (w_ev1) begin
                        if (w_long[1]) begin
                            r_field <= ~r_field;
                        end else if (r_field) begin
                            r_alm_h[r_sel] <= (r_alm_h[r_sel] == 8'd23) ? 8'd0 : (r_alm_h[r_sel] + 8'd1);
                        end else begin
                            r_alm_m[r_sel] <= (r_alm_m[r_sel] == 8'd59) ? 8'd0 : (r_alm_m[r_sel] + 8'd1);
                        end
                    end
                end
            end
        end
    end

    assign disp_hour = r_ring ? r_alm_h[r_ring_idx] : r_alm_h[r_sel];
    assign disp_min  = r_ring ? r_alm_m[r_ring_idx] : r_alm_m[r_sel];
    assign sel_idx   = r_sel;
    assign sel_field = r_field;
    assign armed     = r_armed;
    assign ring      = r_ring;
    assign ring_idx  = r_ring_idx;
    assign snoozing  = r_snz;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_alarm
// Description : Scoreboard bench for multi_alarm against a minute-of-day model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_alarm;

    localparam int N     = 4;
    localparam int DEB   = 2;
    localparam int LNG   = 16;
    localparam int RSECS = 4;
    localparam int SNZ   = 5;

    logic       CLOCK_50;
    logic       reset;
    logic [1:0] KEY;
    logic [1:0] mode;
    logic [7:0] hour;
    logic [7:0] min;
    logic       sec_tick;
    logic [7:0] disp_hour;
    logic [7:0] disp_min;
    logic [1:0] sel_idx;
    logic       sel_field;
    logic [3:0] armed;
    logic       ring;
    logic [1:0] ring_idx;
    logic       snoozing;

    multi_alarm #(
        .N_ALARMS      (N),
        .DEBOUNCE_TICKS(DEB),
        .LONG_TICKS    (LNG),
        .RING_SECS     (RSECS),
        .SNOOZE_MIN    (SNZ)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .KEY      (KEY),
        .mode     (mode),
        .hour     (hour),
        .min      (min),
        .sec_tick (sec_tick),
        .disp_hour(disp_hour),
        .disp_min (disp_min),
        .sel_idx  (sel_idx),
        .sel_field(sel_field),
        .armed    (armed),
        .ring     (ring),
        .ring_idx (ring_idx),
        .snoozing (snoozing)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [7:0] dh;
        logic [7:0] dm;
        logic [1:0] si;
        logic       sf;
        logic [3:0] arm;
        logic       rg;
        logic [1:0] ri;
        logic       sn;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    int         m_h[N];
    int         m_m[N];
    logic [3:0] m_arm;
    int         m_sel;
    logic       m_fld;
    logic       m_ring;
    int         m_ridx;
    logic       m_snz;
    int         m_snz_t;
    int         m_ring_t;
    int         m_sec;
    int         cur_h;
    int         cur_m;

    function automatic exp_t model_exp();
        int d;
        d = m_ring ? m_ridx : m_sel;
        return {8'(m_h[d]), 8'(m_m[d]), 2'(m_sel), m_fld, m_arm, m_ring, 2'(m_ridx), m_snz};
    endfunction

    task automatic push(input string nm);
        exp_q.push_back(model_exp());
        nm_q.push_back(nm);
    endtask

    task automatic check_now(input string nm, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d", nm, act, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_h[i] = 0;
            m_m[i] = 0;
        end
        m_arm = '0; m_sel = 0; m_fld = 1'b0; m_ring = 1'b0; m_ridx = 0;
        m_snz = 1'b0; m_snz_t = 0; m_ring_t = 0; m_sec = 0;
    endtask

    task automatic apply_key(input int k, input bit lng);
        if (m_ring) begin
            m_ring = 1'b0;
            m_sec  = 0;
            if (k == 0) begin
                m_snz = 1'b0;
            end else begin
                m_snz   = 1'b1;
                m_snz_t = (m_ring_t + SNZ) % 1440;
            end
        end else if (mode == 2'd3) begin
            if (k == 0) begin
                if (lng) begin
                    m_sel = (m_sel + 1) % N;
                    m_fld = 1'b0;
                end else begin
                    m_arm[m_sel] = ~m_arm[m_sel];
                end
            end else begin
                if (lng)        m_fld = ~m_fld;
                else if (m_fld) m_h[m_sel] = (m_h[m_sel] + 1) % 24;
                else            m_m[m_sel] = (m_m[m_sel] + 1) % 60;
            end
        end
    endtask

    task automatic press(input bit k0, input bit k1, input bit lng, input string nm);
        KEY = {~k1, ~k0};
        repeat (lng ? 24 : 4) @(posedge CLOCK_50);
        #1;
        KEY = 2'b11;
        repeat (8) @(posedge CLOCK_50);
        #1;
        if (k0)      apply_key(0, lng);
        else if (k1) apply_key(1, lng);
        push(nm);
    endtask

    task automatic step_time(input int h, input int m, input string nm);
        int t;
        int hit;
        hour = 8'(h);
        min  = 8'(m);
        push({nm, "_pre"});
        t = h * 60 + m;
        if (((h != cur_h) || (m != cur_m)) && !m_ring) begin
            hit = -1;
            for (int i = N - 1; i >= 0; i--)
                if (m_arm[i] && (m_h[i] * 60 + m_m[i] == t)) hit = i;
            if ((hit >= 0) || (m_snz && (m_snz_t == t))) begin
                if (m_snz && (m_snz_t == t)) m_snz = 1'b0;
                if (hit >= 0) m_ridx = hit;
                m_ring   = 1'b1;
                m_ring_t = t;
                m_sec    = 0;
            end
        end
        cur_h = h;
        cur_m = m;
        @(posedge CLOCK_50);
        #1;
        push(nm);
    endtask

    task automatic tick(input string nm);
        sec_tick = 1'b1;
        @(posedge CLOCK_50);
        #1;
        sec_tick = 1'b0;
        if (m_ring) begin
            m_sec++;
            if (m_sec == RSECS) begin
                m_ring = 1'b0;
                m_sec  = 0;
            end
        end
        push(nm);
    endtask

    task automatic set_alarm(input int idx, input int h, input int m);
        while (m_sel != idx) press(1, 0, 1, "sel_next");
        if (m_fld) press(0, 1, 1, "fld_min");
        repeat ((m - m_m[idx] + 60) % 60) press(0, 1, 0, "min_inc");
        press(0, 1, 1, "fld_hour");
        repeat ((h - m_h[idx] + 24) % 24) press(0, 1, 0, "hour_inc");
        press(0, 1, 1, "fld_back");
    endtask

    task automatic set_arm(input int idx, input bit val);
        while (m_sel != idx) press(1, 0, 1, "sel_next");
        if (m_arm[idx] != val) press(1, 0, 0, "arm_toggle");
    endtask

    always @(negedge CLOCK_50) begin : monitor
        exp_t  act;
        exp_t  want;
        string nm;
        act = {disp_hour, disp_min, sel_idx, sel_field, armed, ring, ring_idx, snoozing};
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            nm   = nm_q.pop_front();
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL %s: actual dh=%0d dm=%0d sel=%0d fld=%0d arm=%b ring=%0d ridx=%0d snz=%0d, expected dh=%0d dm=%0d sel=%0d fld=%0d arm=%b ring=%0d ridx=%0d snz=%0d",
                         nm, act.dh, act.dm, act.si, act.sf, act.arm, act.rg, act.ri, act.sn,
                         want.dh, want.dm, want.si, want.sf, want.arm, want.rg, want.ri, want.sn);
            end
        end
    end

    initial begin
        int op;
        int idx;
        KEY = 2'b00; mode = 2'd3; hour = 8'd7; min = 8'd0; sec_tick = 1'b0; reset = 1'b1;
        model_reset();
        cur_h = 7;
        cur_m = 0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        KEY   = 2'b11;
        push("reset_state");
        check_now("reset_ring", {7'd0, ring}, 8'd0);
        check_now("reset_armed", {4'd0, armed}, 8'd0);
        check_now("reset_snoozing", {7'd0, snoozing}, 8'd0);
        repeat (12) @(posedge CLOCK_50);
        #1;
        push("no_event_after_reset");

        press(1, 0, 1, "long0_a");
        press(1, 0, 1, "long0_b");
        repeat (30) press(0, 1, 0, "min_inc");
        press(0, 1, 1, "fld_hour");
        repeat (7) press(0, 1, 0, "hour_inc");
        press(1, 0, 0, "arm2");

        step_time(7, 29, "t0729");
        step_time(7, 30, "ring_0730");
        press(1, 0, 0, "dismiss");
        repeat (5) @(posedge CLOCK_50);
        #1;
        push("no_rering");

        step_time(7, 29, "t0729b");
        step_time(7, 30, "ring_0730b");
        press(0, 1, 0, "snooze");
        for (int m = 31; m <= 35; m++) step_time(7, m, "snz_step");
        press(1, 0, 0, "dismiss_snz");

        step_time(7, 29, "t0729c");
        step_time(7, 30, "ring_timeout");
        repeat (RSECS) tick("tick");
        check_now("timeout_expired", {7'd0, ring}, 8'd0);

        set_alarm(2, 23, 58);
        press(0, 1, 0, "min_59");
        press(0, 1, 0, "min_wrap");
        set_alarm(2, 23, 58);
        step_time(23, 57, "t2357");
        step_time(23, 58, "ring_2358");
        press(0, 1, 0, "snooze_2358");
        step_time(23, 59, "t2359");
        for (int m = 0; m <= 3; m++) step_time(0, m, "snz_midnight");
        press(1, 0, 0, "dismiss_0003");

        set_alarm(1, 6, 0);
        set_alarm(3, 6, 0);
        set_arm(1, 1'b1);
        set_arm(3, 1'b1);
        step_time(5, 59, "t0559");
        step_time(6, 0, "lowest_idx");

        KEY = 2'b00;
        repeat (6) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        KEY   = 2'b11;
        @(posedge CLOCK_50);
        #1;
        model_reset();
        push("reset_mid_ring");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge CLOCK_50);
        #1;
        push("after_reset_quiet");

        press(1, 1, 0, "both_short");
        press(1, 1, 1, "both_long");

        mode = 2'd0;
        press(1, 0, 0, "mode0_s0");
        press(0, 1, 0, "mode0_s1");
        press(1, 0, 1, "mode0_l0");
        press(0, 1, 1, "mode0_l1");
        mode = 2'd3;

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1, 2, 3: press(op[1] == 1'b0, op[1] == 1'b1, op[0], "rnd_key");
                4: press(1, 1, $urandom_range(0, 1) == 1, "rnd_both");
                5: begin
                    mode = 2'($urandom_range(0, 3));
                    press($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1, "rnd_mode_k0");
                    press(1'b0, 1'b1, $urandom_range(0, 1) == 1, "rnd_mode_k1");
                    mode = 2'd3;
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        idx = $urandom_range(0, N - 1);
                        step_time(m_h[idx], m_m[idx], "rnd_step_alarm");
                    end else begin
                        step_time($urandom_range(0, 23), $urandom_range(0, 59), "rnd_step");
                    end
                    repeat ($urandom_range(0, 3)) tick("rnd_tick");
                end
            endcase
        end

        repeat (3) @(posedge CLOCK_50);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_alarm.md
# multi_alarm

Parametrised N-channel alarm controller for the watch, used in alarm mode (mode==3). It takes debounced short/long presses on KEY[1:0] to select, edit and arm any of N_ALARMS alarms. On each minute change it compares the timekeeper's hour/min against all armed alarms. It drives a ringing output with dismiss, snooze and auto-timeout, plus binary display values for the existing segment_7 decoders.

## Interface
- N_ALARMS, 4, number of independent alarms (2..8)
- DEBOUNCE_TICKS, 500000, cycles a key level must be stable before it is accepted
- LONG_TICKS, 100000000, cycles of continuous press that define a long press
- RING_SECS, 60, sec_tick pulses before an unanswered ring auto-dismisses
- SNOOZE_MIN, 5, snooze interval in minutes (1..59)
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- KEY  in  2  raw push-buttons, active-low, asynchronous
- mode  in  2  watch mode; editing is enabled only when mode==3
- hour  in  8  current hour, binary 0..23
- min  in  8  current minute, binary 0..59
- sec_tick  in  1  one-cycle pulse per second from the timekeeper
- disp_hour  out  8  hour of the displayed alarm, binary
- disp_min  out  8  minute of the displayed alarm, binary
- sel_idx  out  $clog2(N_ALARMS)  index of the alarm being edited
- sel_field  out  1  0 = minute field, 1 = hour field
- armed  out  N_ALARMS  per-alarm enable
- ring  out  1  alarm sounding
- ring_idx  out  $clog2(N_ALARMS)  alarm that caused the current ring
- snoozing  out  1  a snooze re-ring is pending

## Operation
- Each key path: 2-flop synchroniser, then debounce counter. The debounced level updates only after DEBOUNCE_TICKS identical samples.
- Press tracker per key:
  - SHORT event fires on debounced release if the held count < LONG_TICKS.
  - LONG event fires once, on the cycle the held count reaches LONG_TICKS.
  - After a LONG event, the release produces nothing.
  - The held counter saturates.
- Ringing (any mode):
  - KEY0 SHORT or LONG dismisses the ring.
  - KEY1 SHORT or LONG snoozes: snooze target = ring time + SNOOZE_MIN, minute mod 60, hour carry mod 24. snoozing=1.
  - Key events consumed here never reach editing.
- Editing (mode==3, not ringing):
  - KEY0 SHORT: toggle armed[sel_idx].
  - KEY0 LONG: sel_idx = (sel_idx+1) mod N_ALARMS, sel_field=0.
  - KEY1 SHORT: increment the selected field. Minute wraps 59->0 with no hour carry; hour wraps 23->0.
  - KEY1 LONG: toggle sel_field.
- Key events outside mode==3 (not ringing) are discarded.
- If events from both keys occur in the same cycle, KEY0 is processed and KEY1 is dropped.
- Match detection runs only on a minute-change cycle, i.e. hour or min differs from its value registered the previous cycle.
  - Trigger when any armed alarm equals {hour,min}, or snoozing and the snooze target equals {hour,min}.
  - ring_idx = lowest matching index; a snooze match keeps the previous ring_idx.
  - A snooze trigger clears snoozing.
  - A match while already ringing is ignored and does not restart the timeout.
- Editing an alarm to the current time does not ring until the next minute change that matches.
- Ring timeout: counts sec_tick while ring=1. Reaching RING_SECS clears ring as a dismiss; snoozing is unchanged.
- Dismiss clears any pending snooze.
- disp_hour/disp_min show alarm[ring_idx] while ringing, otherwise alarm[sel_idx].
- Reset values:
  - All alarms 00:00, armed=0, sel_idx=0, sel_field=0, ring=0, ring_idx=0, snoozing=0.
  - Counters 0, debounced keys released.
  - Previous hour/min registers load the current inputs, so reset never creates a minute-change event.

## Timing
- Raw key to debounced level: 2 + DEBOUNCE_TICKS cycles.
- SHORT/LONG event to register update: 1 cycle. Updated armed, sel_*, disp_* are visible on the next edge.
- Minute-change input to ring=1: 1 cycle. ring_idx is valid in the same cycle as ring.
- Dismiss/snooze event to ring=0: 1 cycle.
- reset has priority over every event in the same cycle. Reset mid-ring or mid-press aborts with no event emitted.
- Pressing both keys during reset: the trackers start released and require a full debounced press after reset.

## Test plan
- Params DEBOUNCE_TICKS=2, LONG_TICKS=16, RING_SECS=4, SNOOZE_MIN=5, N_ALARMS=4; mode=3. Set alarm2 to 07:30:
  - KEY0 long twice -> sel_idx=2.
  - 30 KEY1 shorts -> disp_min=30.
  - KEY1 long -> sel_field=1.
  - 7 KEY1 shorts -> disp_hour=7.
  - KEY0 short -> armed=4'b0100.
- Alarm2 armed 07:30; step time 07:29->07:30 -> ring=1 and ring_idx=2 one cycle later. KEY0 short -> ring=0 and snoozing=0. Time held at 07:30 -> no re-ring.
- Ring on 07:30, KEY1 short -> ring=0, snoozing=1. Step time to 07:35 -> ring=1, snoozing=0. Also ring at 23:58 with snooze -> re-ring at 00:03.
- Ring with no key activity: 4 sec_ticks -> ring=0 on the cycle after the 4th tick.
- Alarms 1 and 3 both armed at 06:00; time reaches 06:00 -> ring_idx=1.
- Minute at 59, KEY1 short -> 00 with disp_hour unchanged.
- KEY0 and KEY1 events in the same cycle -> only the KEY0 effect occurs.
- mode=0: key presses leave all state unchanged.
- reset asserted while ringing -> all outputs at their reset values next cycle.
